// File: rtl/timera_prediv.sv
// timera_prediv: clock-source selector and prescaler for Timer_A.
// Four asynchronous sources are synchronized into MCLK, and a rising-edge pulse is
// taken from the source selected by TASSEL. Those rises are divided by
// N = (2^ID)*(IDEX+1), which ranges over 1..64.
//
// Ports:
//   MCLK        system clock; all logic runs on its rising edge
//   reset       asynchronous active-low reset
//   TAxCLK, ACLK, SMCLK, INCLK   asynchronous timer clock sources
//   wTACLR      synchronous prescaler clear (one-MCLK pulse)
//   TASSEL[1:0] source select (00 TAxCLK, 01 ACLK, 10 SMCLK, 11 INCLK)
//   ID[1:0]     first divider /1,/2,/4,/8
//   IDEX[2:0]   second divider /(IDEX+1)
//   TimerClock  divided clock level (registered)
//   TimerTick   one-cycle count enable for each TimerClock rising event (registered)
//
// Optional feature, enabled by defining TIMERA_PREDIV_DBG_EN:
//   PreDivCount[5:0] = prescaler count, PreDivN[6:0] = current divide ratio.
module timera_prediv #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       TAxCLK,
  input  logic       ACLK,
  input  logic       SMCLK,
  input  logic       INCLK,
  input  logic       wTACLR,
  input  logic [1:0] TASSEL,
  input  logic [1:0] ID,
  input  logic [2:0] IDEX,
  output logic       TimerClock,
  output logic       TimerTick
`ifdef TIMERA_PREDIV_DBG_EN
  ,
  output logic [5:0] PreDivCount,
  output logic [6:0] PreDivN
`endif
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned SS   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned CW   = 6;
  localparam int unsigned NW   = 7;

  logic [NSRC-1:0]         src;
  logic [NSRC-1:0][SS-1:0] sync_q;
  logic [NSRC-1:0]         lvl;
  logic [NSRC-1:0]         prev_q;
  logic [NSRC-1:0]         rise;
  logic                    sel_rise;
  logic                    sel_lvl;
  logic [NW-1:0]           n_div;
  logic [NW-1:0]           half;
  logic [CW-1:0]           n_m1;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    clk_q, clk_d;
  logic                    tick_q, tick_d;

  assign src = {INCLK, SMCLK, ACLK, TAxCLK};

  // Per-source synchronizer chain plus previous-sample flop
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        sync_q[i] <= {sync_q[i][SS-2:0], src[i]};
      end
      prev_q <= lvl;
    end
  end

  // Synchronized levels and rising-edge pulses
  always_comb begin
    lvl = '0;
    for (int i = 0; i < NSRC; i++) begin
      lvl[i] = sync_q[i][SS-1];
    end
  end

  assign rise = lvl & ~prev_q;

  // Edge pulses (not levels) are muxed so that a select change cannot fabricate an edge
  assign sel_rise = rise[TASSEL];
  assign sel_lvl  = lvl[TASSEL];

  // Divide ratio N, N-1 (terminal count) and ceil(N/2) (high-phase length)
  assign n_div = NW'(({4'd0, IDEX} + 7'd1) << ID);
  assign n_m1  = CW'(n_div - NW'(1));
  assign half  = NW'((n_div + NW'(1)) >> 1);

  // Prescaler next state
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (wTACLR) begin
      cnt_d = n_m1;
      clk_d = 1'b0;
    end else begin
      if (sel_rise) begin
        // >= rather than == so that a shrunken N wraps instead of running to 63
        if (cnt_q >= n_m1) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      if (n_div == NW'(1)) begin
        clk_d = sel_lvl;
      end else if (sel_rise) begin
        clk_d = ({1'b0, cnt_d} < half);
      end
    end
  end

  // Prescaler registers; all-ones count is >= any N-1, so the first rise after reset wraps
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '1;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign TimerClock = clk_q;
  assign TimerTick  = tick_q;

`ifdef TIMERA_PREDIV_DBG_EN
  assign PreDivCount = cnt_q;
  assign PreDivN     = n_div;
`endif

endmodule

// File: tb/tb_timera_prediv.sv
// Testbench for timera_prediv: free-running sources, directed scenarios with literal
// expectations, and a per-cycle comparison against a behavioural divider model.
module tb_timera_prediv;

  localparam int S = 2;

  logic       MCLK = 1'b0;
  logic       reset;
  logic       wTACLR;
  logic [1:0] TASSEL;
  logic [1:0] ID;
  logic [2:0] IDEX;
  logic [3:0] raw;
  logic       TimerClock;
  logic       TimerTick;
`ifdef TIMERA_PREDIV_DBG_EN
  logic [5:0] PreDivCount;
  logic [6:0] PreDivN;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int per [4] = '{14, 23, 10, 31};
  int ph [4];
  int rise_cyc [4];

  timera_prediv #(.SYNC_STAGES(S)) dut (
    .MCLK       (MCLK),
    .reset      (reset),
    .TAxCLK     (raw[0]),
    .ACLK       (raw[1]),
    .SMCLK      (raw[2]),
    .INCLK      (raw[3]),
    .wTACLR     (wTACLR),
    .TASSEL     (TASSEL),
    .ID         (ID),
    .IDEX       (IDEX),
    .TimerClock (TimerClock),
    .TimerTick  (TimerTick)
`ifdef TIMERA_PREDIV_DBG_EN
    ,
    .PreDivCount(PreDivCount),
    .PreDivN    (PreDivN)
`endif
  );

  initial forever #5 MCLK = ~MCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Sources: level high for floor(P/2) cycles of each P-cycle period; rise_cyc records
  // the cycle after whose edge the source went high
  initial begin
    bit nv;
    raw = '0;
    for (int i = 0; i < 4; i++) begin
      ph[i] = 0;
      rise_cyc[i] = -100;
    end
    forever begin
      @(posedge MCLK);
      cyc++;
      #1;
      for (int i = 0; i < 4; i++) begin
        ph[i] = (ph[i] + 1) % per[i];
        nv = (ph[i] < per[i] / 2);
        if (nv && !raw[i]) rise_cyc[i] = cyc;
        raw[i] = nv;
      end
    end
  end

  // Behavioural model: a source level reaches the divider S cycles after being captured;
  // the divider counts rises modulo N with an integer, high while count < ceil(N/2)
  logic [3:0] h [S+1];
  int m_cnt  = 1000;
  bit m_clk  = 1'b0;
  bit m_tick = 1'b0;

  initial begin
    int nd;
    bit lv, rs;
    for (int k = 0; k <= S; k++) h[k] = '0;
    forever begin
      @(posedge MCLK or negedge reset);
      if (!reset) begin
        for (int k = 0; k <= S; k++) h[k] = '0;
        m_cnt  = 1000;
        m_clk  = 1'b0;
        m_tick = 1'b0;
      end else begin
        nd = (1 << ID) * (int'(IDEX) + 1);
        lv = h[S-1][TASSEL];
        rs = lv && !h[S][TASSEL];
        m_tick = 1'b0;
        if (wTACLR) begin
          m_cnt = nd - 1;
          m_clk = 1'b0;
        end else begin
          if (rs) begin
            if (m_cnt >= nd - 1) begin
              m_cnt  = 0;
              m_tick = 1'b1;
            end else begin
              m_cnt++;
            end
          end
          if (nd == 1) m_clk = lv;
          else if (rs) m_clk = (m_cnt < (nd + 1) / 2);
        end
        for (int k = S; k > 0; k--) h[k] = h[k-1];
        h[0] = raw;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model, plus the no-back-to-back-tick rule
  initial begin
    bit prev_tick;
    prev_tick = 1'b0;
    forever begin
      @(negedge MCLK);
      chk("model_clk", TimerClock, m_clk);
      chk("model_tick", TimerTick, m_tick);
      if (TimerTick === 1'b1) begin
        n_cmp++;
        if (prev_tick) begin
          n_err++;
          $display("FAIL tick_consecutive at cyc %0d: got 2 high cycles, expected 1", cyc);
        end
      end
      prev_tick = (TimerTick === 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  task automatic wait_tick(input int bound, output int tc);
    bit done;
    done = 1'b0;
    tc = -1;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge MCLK);
      if (TimerTick === 1'b1) begin
        tc = cyc;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_timeout at cyc %0d: got no tick in %0d cycles, expected one", cyc, bound);
    end
  endtask

  task automatic wait_rise(input int s, input int bound, output int rc);
    bit done;
    done = 1'b0;
    rc = -1;
    for (int k = 0; k < bound && !done; k++) begin
      @(posedge MCLK);
      #2;
      if (rise_cyc[s] == cyc) begin
        rc = cyc;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL rise_timeout at cyc %0d: got no source rise, expected one", cyc);
    end
  endtask

  task automatic pulse_clear();
    step(1);
    wTACLR = 1'b1;
    step(1);
    wTACLR = 1'b0;
    chk("clr_clk", TimerClock, 0);
    chk("clr_tick", TimerTick, 0);
  endtask

  initial begin
    int rc, a, b, n;
    reset  = 1'b0;
    wTACLR = 1'b0;
    TASSEL = 2'd0;
    ID     = 2'd0;
    IDEX   = 3'd0;
    step(3);
    chk("rst_clk", TimerClock, 0);
    chk("rst_tick", TimerTick, 0);
    reset = 1'b1;

    // TAxCLK /1: tick S+1 cycles after the source is driven high, then every 14 cycles
    step(20);
    wait_rise(0, 40, rc);
    wait_tick(20, a);
    chk("t1_latency", a - rc, S + 1);
    chk("t1_clk_high", TimerClock, 1);
    for (int k = 0; k < 9; k++) begin
      wait_tick(40, b);
      chk("t1_spacing", b - a, 14);
      a = b;
    end

    // Source switching at /1
    for (int s = 1; s < 4; s++) begin
      step(3);
      TASSEL = 2'(s);
      wait_tick(80, a);
      chk("sw_align", a - rise_cyc[s], S + 1);
      wait_tick(80, b);
      chk("sw_spacing", b - a, per[s]);
    end

    // Divider sweep on SMCLK (period 10)
    step(1);
    TASSEL = 2'd2;
    for (int i = 0; i < 32; i++) begin
      step(1);
      ID   = 2'(i >> 3);
      IDEX = 3'(i & 7);
      pulse_clear();
      n = (1 << (i >> 3)) * ((i & 7) + 1);
      wait_tick(40, a);
      wait_tick(10 * n + 40, b);
      chk("sweep_spacing", b - a, 10 * n);
      if (i == 1)  chk("cp_n2", b - a, 20);
      if (i == 18) chk("cp_n12", b - a, 120);
      if (i == 31) chk("cp_n64", b - a, 640);
    end

    // /64: clear mid-count, first tick on the next source rise, then 64 periods
    step(200);
    wait_rise(2, 30, rc);
    step(4);
    pulse_clear();
    wait_rise(2, 30, rc);
    wait_tick(20, a);
    chk("d64_first", a - rc, S + 1);
    wait_tick(700, b);
    chk("d64_spacing", b - a, 640);

    // Asynchronous reset pulse mid-count while SMCLK is low
    wait_rise(2, 30, rc);
    step(6);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_clk", TimerClock, 0);
    chk("arst_tick", TimerTick, 0);
    @(posedge MCLK);
    #3;
    reset = 1'b1;
    wait_rise(2, 30, rc);
    wait_tick(20, a);
    chk("arst_first", a - rc, S + 1);
    wait_tick(700, b);
    chk("arst_spacing", b - a, 640);

    // Clear on the same edge as a selected rise: rise dropped, count primed
    wait_rise(2, 30, rc);
    step(S);
    wTACLR = 1'b1;
    step(1);
    wTACLR = 1'b0;
    chk("coinc_tick", TimerTick, 0);
    chk("coinc_clk", TimerClock, 0);
    wait_tick(30, a);
    chk("coinc_next", a - rc, 10 + S + 1);

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
